// File: rtl/lsu.sv
// Load/store unit: turns single RV32I MEM-stage requests into word accesses
// on a registered-read data memory. Sub-word stores are read-modify-write.
module lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_write_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_CAP  = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [31:0] r_maddr;
  logic [31:0] r_wr_data;

  logic        w_req_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  // Classify an incoming request as illegal (bad funct3 or misaligned)
  always_comb begin
    w_req_err = 1'b0;
    if (req_we) begin
      if (req_funct3[2] || (req_funct3[1:0] == 2'b11)) w_req_err = 1'b1;
    end else begin
      if ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11)) w_req_err = 1'b1;
    end
    if ((req_funct3[1:0] == 2'b01) && req_addr[0]) w_req_err = 1'b1;
    if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) w_req_err = 1'b1;
  end

  // Lane extraction/extension for loads and lane merge for sub-word stores
  always_comb begin
    case (r_lane)
      2'd0:    w_byte = mem_read_data[7:0];
      2'd1:    w_byte = mem_read_data[15:8];
      2'd2:    w_byte = mem_read_data[23:16];
      default: w_byte = mem_read_data[31:24];
    endcase
    w_half = r_lane[1] ? mem_read_data[31:16] : mem_read_data[15:0];

    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b010:  w_load = mem_read_data;
      3'b100:  w_load = {24'h000000, w_byte};
      3'b101:  w_load = {16'h0000, w_half};
      default: w_load = '0;
    endcase

    w_merge = mem_read_data;
    if (r_funct3[1:0] == 2'b00) begin
      case (r_lane)
        2'd0:    w_merge[7:0]   = r_wdata[7:0];
        2'd1:    w_merge[15:8]  = r_wdata[7:0];
        2'd2:    w_merge[23:16] = r_wdata[7:0];
        default: w_merge[31:24] = r_wdata[7:0];
      endcase
    end else if (r_funct3[1:0] == 2'b01) begin
      if (r_lane[1]) w_merge[31:16] = r_wdata;
      else           w_merge[15:0]  = r_wdata;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state and strobe decode; the write strobe is also gated by rst_n so
  // a reset landing in WR aborts the store in the same cycle
  always_comb begin
    w_next       = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    mem_write_en = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_req_err)                            w_next = RESP;
          else if (req_we && req_funct3 == 3'b010)  w_next = WR;
          else                                      w_next = RD_ADDR;
        end
      end
      RD_ADDR: w_next = RD_CAP;
      RD_CAP:  w_next = r_we ? WR : RESP;
      WR: begin
        mem_write_en = rst_n;
        w_next       = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Request capture on accept, load/merge capture in RD_CAP
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we      <= 1'b0;
      r_funct3  <= '0;
      r_lane    <= '0;
      r_wdata   <= '0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_maddr   <= '0;
      r_wr_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we      <= req_we;
            r_funct3  <= req_funct3;
            r_lane    <= req_addr[1:0];
            r_wdata   <= req_wdata[15:0];
            r_err     <= w_req_err;
            r_rdata   <= '0;
            r_maddr   <= {req_addr[31:2], 2'b00};
            r_wr_data <= req_wdata;
          end
        end
        RD_CAP: begin
          if (r_we) r_wr_data <= w_merge;
          else      r_rdata   <= w_load;
        end
        default: ;
      endcase
    end
  end

  assign resp_rdata     = r_rdata;
  assign resp_err       = r_err;
  assign mem_addr       = r_maddr;
  assign mem_write_data = r_wr_data;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a registered-read word memory model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:255];
  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [31:0] bd_data;

  int errors = 0;
  int checks = 0;

  lsu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_write_en   (mem_write_en),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  // Memory: backdoor preload, strobed word write, 1-cycle registered read
  always @(posedge clk) begin
    if (bd_we)             mem[bd_addr] <= bd_data;
    else if (mem_write_en) mem[mem_addr[9:2]] <= mem_write_data;
    mem_read_data <= mem[mem_addr[9:2]];
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
    logic        chk_mem;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bd_we   = 1'b1;
    bd_addr = addr[9:2];
    bd_data = data;
    @(negedge clk);
    bd_we   = 1'b0;
  endtask

  task automatic do_req(input vec_t v, input int idx);
    int          lat;
    int          wr;
    int          n;
    logic [31:0] got_rdata;
    logic        got_err;
    string       tag;
    lat = 0;
    wr  = 0;
    n   = 0;
    got_rdata = '0;
    got_err   = 1'b0;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_write_en) begin
        wr++;
        chk({tag, "_wr_addr"}, mem_addr, {v.addr[31:2], 2'b00});
      end
      if (resp_valid) begin
        lat       = c;
        got_rdata = resp_rdata;
        got_err   = resp_err;
        break;
      end
    end
    chk({tag, "_lat"},   lat, v.exp_lat);
    chk({tag, "_rdata"}, got_rdata, v.exp_rdata);
    chk({tag, "_err"},   {31'b0, got_err}, {31'b0, v.exp_err});
    chk({tag, "_writes"}, wr, v.exp_wr);
    @(negedge clk);
    chk({tag, "_pulse_end"}, {31'b0, resp_valid}, 32'd0);
    chk({tag, "_ready_after"}, {31'b0, req_ready}, 32'd1);
    if (v.chk_mem) chk({tag, "_mem"}, mem[v.addr[9:2]], v.exp_mem);
  endtask

  initial begin
    int          exp_ready [1:7];
    int          exp_valid [1:7];
    int          wr;
    logic [31:0] b2b_rdata;

    //            we   f3      addr          wdata         rdata         err lat wr chk mem
    vecs[0]  = '{1'b0, 3'b000, 32'h103, 32'h0,        32'hFFFFFF80, 1'b0, 3, 0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 3'b101, 32'h102, 32'h0,        32'h00008081, 1'b0, 3, 0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 3'b001, 32'h100, 32'h0,        32'hFFFF82F3, 1'b0, 3, 0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'h808182F3, 1'b0, 3, 0, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 3'b100, 32'h100, 32'h0,        32'h000000F3, 1'b0, 3, 0, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 3'b000, 32'h101, 32'h123456AA, 32'h0,        1'b0, 4, 1, 1'b1, 32'h8081AAF3};
    vecs[6]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'h8081AAF3, 1'b0, 3, 0, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 3'b010, 32'h102, 32'h0,        32'h0,        1'b1, 1, 0, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 3'b001, 32'h103, 32'h9999,     32'h0,        1'b1, 1, 0, 1'b1, 32'h8081AAF3};
    vecs[9]  = '{1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        1'b1, 1, 0, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 3'b100, 32'h100, 32'h77,       32'h0,        1'b1, 1, 0, 1'b1, 32'h8081AAF3};
    vecs[11] = '{1'b1, 3'b001, 32'h102, 32'hFFFF5555, 32'h0,        1'b0, 4, 1, 1'b1, 32'h5555AAF3};
    vecs[12] = '{1'b1, 3'b010, 32'h108, 32'hCAFEF00D, 32'h0,        1'b0, 2, 1, 1'b1, 32'hCAFEF00D};
    vecs[13] = '{1'b0, 3'b001, 32'h102, 32'h0,        32'h00005555, 1'b0, 3, 0, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 3'b000, 32'h101, 32'h0,        32'hFFFFFFAA, 1'b0, 3, 0, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 3'b010, 32'h108, 32'h0,        32'hCAFEF00D, 1'b0, 3, 0, 1'b0, 32'h0};

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    bd_we      = 1'b0;
    bd_addr    = '0;
    bd_data    = '0;

    preload(32'h100, 32'h808182F3);
    preload(32'h104, 32'h11223344);
    preload(32'h108, 32'h0);
    preload(32'h10C, 32'h0);

    // Reset values while held in reset
    @(negedge clk);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err",   {31'b0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_addr",   mem_addr, 32'd0);
    chk("rst_mem_wdata",  mem_write_data, 32'd0);
    chk("rst_mem_we",     {31'b0, mem_write_en}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < 16; i++) do_req(vecs[i], i);

    // Reset arriving while a SW sits in WR aborts the write
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h104;
    req_wdata  = 32'hDEADBEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_wr_we_before", {31'b0, mem_write_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_we_in_reset", {31'b0, mem_write_en}, 32'd0);
    @(negedge clk);
    chk("abort_we_next", {31'b0, mem_write_en}, 32'd0);
    chk("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_mem", mem[8'h41], 32'h11223344);

    // Back-to-back LW then SW with req_valid held high
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h104;
    req_wdata  = 32'h0;
    @(posedge clk);
    #1;
    req_we     = 1'b1;
    req_addr   = 32'h10C;
    req_wdata  = 32'h0BADF00D;
    exp_ready  = '{0, 0, 0, 1, 0, 0, 1};
    exp_valid  = '{0, 0, 1, 0, 0, 1, 0};
    wr         = 0;
    b2b_rdata  = '0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk($sformatf("b2b_ready_c%0d", c), {31'b0, req_ready}, exp_ready[c]);
      chk($sformatf("b2b_valid_c%0d", c), {31'b0, resp_valid}, exp_valid[c]);
      if (c == 3) b2b_rdata = resp_rdata;
      if (c == 6) chk("b2b_sw_rdata", resp_rdata, 32'd0);
      if (mem_write_en) begin
        wr++;
        chk("b2b_wr_addr", mem_addr, 32'h10C);
      end
      if (c == 4) begin
        @(posedge clk);
        #1 req_valid = 1'b0;
      end
    end
    chk("b2b_lw_rdata", b2b_rdata, 32'h11223344);
    chk("b2b_writes", wr, 32'd1);
    chk("b2b_mem", mem[8'h43], 32'h0BADF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
